// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a byte FIFO in front of the LSB-first serialiser.
// Latency: a byte pushed into an empty FIFO while idle puts the start bit on the line one edge later; frame = 10*DIV cycles.
// Backpressure: ready_o low only while the FIFO is full; a pop on the same edge does not let a push through.
// Ports: clk_i / rst_ni        clock, asynchronous active-low reset
//        data_i/valid_i/ready_o byte input handshake (push on valid_i && ready_o)
//        serial_out             registered TX line, idle high
//        busy_o                 frame on the line or FIFO non-empty
//        count_o                FIFO occupancy, 0..2**DEPTH_LOG2
module uart_tx #(
  parameter int CLKFREQ    = 50000000,
  parameter int BAUD       = 9600,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  serial_out,
  output logic                  busy_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DIV   = CLKFREQ / BAUD;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OCW   = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [OCW-1:0] FULL    = OCW'(DEPTH);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLKFREQ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [OCW-1:0]        r_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_ne;
  logic [7:0]            w_head;

  // Serialiser state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_nxt;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic                  r_serial;
  logic                  w_serial_nxt;
  logic                  w_period_end;

  assign ready_o   = (r_count != FULL);
  assign w_push    = valid_i && ready_o;
  assign w_fifo_ne = (r_count != '0);
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_serial <= w_serial_nxt;
    end
  end

  assign w_period_end = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_serial_nxt = r_serial;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt    = '0;
        w_serial_nxt = 1'b1;
        if (w_fifo_ne) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_head;
          w_serial_nxt = 1'b0;
          w_state_nxt  = START;
        end
      end
      START: begin
        if (w_period_end) begin
          w_cnt_nxt    = '0;
          w_serial_nxt = r_shift[0];
          w_idx_nxt    = '0;
          w_state_nxt  = DATA;
        end
      end
      DATA: begin
        if (w_period_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_serial_nxt = 1'b1;
            w_state_nxt  = STOP;
          end else begin
            // The bit after the shift is the current bit 1.
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_serial_nxt = r_shift[1];
            w_idx_nxt    = r_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_period_end) begin
          w_cnt_nxt = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (w_fifo_ne) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_head;
            w_serial_nxt = 1'b0;
            w_state_nxt  = START;
          end else begin
            w_state_nxt  = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_serial_nxt = 1'b1;
      end
    endcase
  end

  assign serial_out = r_serial;
  assign busy_o     = (r_state != IDLE) || w_fifo_ne;
  assign count_o    = r_count;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboarded bench for uart_tx with a line-level receiver model.
// Latency: n/a (bench).
// Backpressure: stimulus holds valid_i until the DUT accepts.
module tb_uart_tx;

  localparam int CLKFREQ = 160;
  localparam int BAUD    = 10;
  localparam int DIV     = CLKFREQ / BAUD;
  localparam int DL2     = 2;
  localparam int FRAME   = 10 * DIV;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [7:0]     data_i;
  logic           valid_i;
  logic           ready_o;
  logic           serial_out;
  logic           busy_o;
  logic [DL2:0]   count_o;

  int             errors = 0;
  int             checks = 0;
  int             cyc = 0;
  int             n_acc = 0;
  int             n_rx = 0;
  int             last_push_edge = 0;
  logic [7:0]     exp_q[$];
  int             fall_q[$];
  bit             rx_active = 1'b0;
  int             rx_t = 0;
  logic [7:0]     rx_byte = 8'h00;

  uart_tx #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .DEPTH_LOG2(DL2)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .serial_out (serial_out),
    .busy_o     (busy_o),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge counter: at the negedge after rising edge n, cyc == n+1.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard producer: every accepted byte is expected on the line in order.
  always @(posedge clk_i) begin
    if (rst_ni && valid_i && ready_o) begin
      exp_q.push_back(data_i);
      last_push_edge = cyc;
      n_acc++;
    end
  end

  // Receiver model: find the start edge, sample each bit near its centre.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (serial_out === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
        fall_q.push_back(cyc - 1);
      end
    end else begin
      rx_t++;
      if (rx_t == DIV/2 - 1) begin
        chk("start_bit", serial_out, 1'b0);
      end else if (rx_t > DIV/2 - 1 && rx_t < 9*DIV + DIV/2 - 1 && (rx_t % DIV) == DIV/2 - 1) begin
        rx_byte[rx_t/DIV - 1] = serial_out;
      end else if (rx_t == 9*DIV + DIV/2 - 1) begin
        chk("stop_bit", serial_out, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %02h with no byte outstanding", rx_byte);
        end else begin
          chk("rx_byte", rx_byte, exp_q.pop_front());
        end
        n_rx++;
        rx_active = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int t = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (!ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_o=%0b after %0d cycles, byte %02h", ready_o, t, b);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    data_i  = 8'($urandom);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int t = 0;
    while ((busy_o || rx_active || exp_q.size() != 0) && t < limit) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (busy_o || rx_active || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: not idle after %0d cycles, busy=%0b outstanding=%0d", name, t, busy_o, exp_q.size());
    end
  endtask

  task automatic wait_fall(input int n, input int limit);
    int t = 0;
    while (fall_q.size() < n && t < limit) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (fall_q.size() < n) begin
      errors++;
      $display("FAIL wait_fall: got %0d start bits, expected %0d", fall_q.size(), n);
    end
  endtask

  task automatic wait_cyc(input int target);
    int t = 0;
    while (cyc < target && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
  endtask

  initial begin
    int e;
    int f;
    int base;
    int rx0;
    int t;
    logic [7:0] blist [6];
    blist = '{8'h3C, 8'h81, 8'h5A, 8'hE7, 8'h12, 8'h99};

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_count",  count_o, 0);
    chk("rst_ready",  ready_o, 1'b1);
    chk("rst_busy",   busy_o, 1'b0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single byte: start one edge after push, busy drops at E+161
    fall_q.delete();
    send(8'hA5);
    e = last_push_edge;
    wait_fall(1, 50);
    if (fall_q.size() >= 1) chk("latency", fall_q[0] - e, 1);
    wait_idle("single_idle", 400);
    chk("busy_drop", (cyc - 1) - e, FRAME + 1);
    chk("single_serial", serial_out, 1'b1);

    // Back-to-back 0x00, 0xFF
    repeat (5) @(negedge clk_i);
    fall_q.delete();
    send(8'h00);
    chk("b2b_count_a", count_o, 1);
    send(8'hFF);
    chk("b2b_count_b", count_o, 1);
    wait_idle("b2b_idle", 600);
    chk("b2b_frames", fall_q.size(), 2);
    if (fall_q.size() >= 2) chk("b2b_gap", fall_q[1] - fall_q[0], FRAME);
    chk("b2b_count_end", count_o, 0);

    // Full FIFO with valid held high over six distinct bytes
    repeat (5) @(negedge clk_i);
    fall_q.delete();
    base    = n_acc;
    rx0     = n_rx;
    valid_i = 1'b1;
    data_i  = blist[0];
    t = 0;
    while (count_o != 4 && t < 20) begin
      @(negedge clk_i);
      t++;
      if (n_acc - base < 6) data_i = blist[n_acc - base];
    end
    chk("full_count", count_o, 4);
    chk("full_ready", ready_o, 1'b0);
    chk("full_accepted", n_acc - base, 5);
    t = 0;
    while (count_o == 4 && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    chk("full_no_push_through", count_o, 3);
    chk("full_accepted_pop", n_acc - base, 5);
    valid_i = 1'b0;
    wait_idle("full_idle", 1200);
    chk("full_frames", n_rx - rx0, 5);

    // Push on the pop edge at the end of STOP with one byte queued
    repeat (5) @(negedge clk_i);
    fall_q.delete();
    send(8'hC3);
    e = last_push_edge;
    repeat (4) @(negedge clk_i);
    send(8'h5E);
    wait_cyc(e + FRAME + 1);
    chk("pp_pre_count", count_o, 1);
    data_i  = 8'h7B;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("pp_count", count_o, 1);
    chk("pp_push_edge", last_push_edge - e, FRAME + 1);
    wait_idle("pp_idle", 800);
    chk("pp_frames", fall_q.size(), 3);
    if (fall_q.size() >= 3) begin
      chk("pp_gap1", fall_q[1] - fall_q[0], FRAME);
      chk("pp_gap2", fall_q[2] - fall_q[1], FRAME);
    end

    // Reset during data bit 3 with two bytes queued
    repeat (5) @(negedge clk_i);
    fall_q.delete();
    send(8'h6D);
    send(8'hB2);
    send(8'h4F);
    wait_fall(1, 50);
    f = (fall_q.size() >= 1) ? fall_q[0] : cyc;
    wait_cyc(f + 4*DIV + DIV/2);
    rx0 = n_rx;
    rst_ni = 1'b0;
    #1;
    chk("arst_serial", serial_out, 1'b1);
    chk("arst_count",  count_o, 0);
    chk("arst_busy",   busy_o, 1'b0);
    chk("arst_ready",  ready_o, 1'b1);
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    fall_q.delete();
    t = 0;
    repeat (400) begin
      @(negedge clk_i);
      if (serial_out !== 1'b1) t++;
    end
    chk("arst_low_cycles", t, 0);
    chk("arst_no_frames", fall_q.size(), 0);
    chk("arst_rx", n_rx - rx0, 0);
    chk("arst_count_after", count_o, 0);

    // Loopback-style sweep 0x00..0xFF with random gaps and garbage on data_i
    rx0 = n_rx;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 3)) begin
        data_i = 8'($urandom);
        @(negedge clk_i);
      end
      send(8'(i));
    end
    wait_idle("sweep_idle", 2000);
    chk("sweep_frames", n_rx - rx0, 256);
    chk("sweep_count", count_o, 0);
    chk("sweep_serial", serial_out, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit-side counterpart to the team's UART receiver.
- Accepts bytes from a bus-side producer over a valid/ready handshake into a small internal FIFO.
- Serialises them LSB-first on serial_out with its own bit-period counter.
- Sits between the CPU/peripheral bus and the board TX pin.

Parameters:
- CLKFREQ, 50000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bits/s. Bit period DIV = CLKFREQ/BAUD, integer-truncated; elaboration error if DIV < 2.
- DEPTH_LOG2, 2, FIFO depth is 2**DEPTH_LOG2 entries (default 4).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- data_i  input  8  byte to transmit.
- valid_i  input  1  producer has a byte on data_i.
- ready_o  output  1  FIFO can accept a byte (not full).
- serial_out  output  1  UART line, idle high; registered output.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- count_o  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.

Behaviour:
Reset (rst_ni low, asynchronous):
- serial_out=1, FIFO emptied (count_o=0), ready_o=1, busy_o=0, FSM=IDLE, bit counter and bit index cleared.
- Reset asserted mid-frame aborts the frame immediately; the line returns high with no stop bit.

Handshake and FIFO:
- Push occurs on a rising edge with valid_i && ready_o; data_i is captured.
- ready_o = (count_o != 2**DEPTH_LOG2), combinational from occupancy only.
- While full, valid_i is ignored, even if a pop happens on the same edge (no push-through).
- Simultaneous push and pop when not full: count_o unchanged and both operations take effect.
- Read/write pointers wrap modulo depth; count_o is never driven outside 0..depth.

FSM states: IDLE, START, DATA, STOP.
- IDLE: serial_out=1. On an edge where the FIFO is non-empty, pop the head into a shift register, set serial_out=0, clear the bit counter, and go to START.
- START: hold 0 for DIV cycles. When the bit counter reaches DIV-1, drive shift[0], set the bit index to 0, and go to DATA.
- DATA: each bit is held DIV cycles, shifting right at each period end. After bit index 7 completes, set serial_out=1 and go to STOP.
- STOP: hold 1 for DIV cycles. At the end of the period:
  - if the FIFO is non-empty, pop, drive 0, and go directly to START (no idle gap);
  - otherwise go to IDLE.

Timing:
- Bit counter counts 0..DIV-1 and restarts at every state change.
- Latency: a byte pushed at edge E into an empty FIFO with the FSM in IDLE has serial_out fall at edge E+1.
- Frame length is exactly 10*DIV cycles. Back-to-back frames are seamless.
- busy_o = (FSM != IDLE) || (count_o != 0).
- data_i changes after acceptance never affect a byte already in the FIFO or in flight.

Test Plan:
- Single byte, CLKFREQ=160, BAUD=10 (DIV=16): push 0xA5 at edge E -> serial_out falls at E+1. Sampling at bit centres gives 0, 1,0,1,0,0,1,0,1, 1. Line returns to IDLE at E+161 and busy_o drops then.
- Back-to-back: push 0x00 and 0xFF on consecutive edges -> two 160-cycle frames with no gap; second start bit begins exactly 160 cycles after the first. count_o goes 1 -> 1 -> 0 as pops occur.
- Full FIFO: hold valid_i high with 6 distinct bytes, DEPTH_LOG2=2 -> ready_o drops when count_o=4. Exactly the first 5 bytes are accepted (one popped immediately). All accepted bytes are transmitted in order and no byte is duplicated.
- Push on the pop edge: with count_o=1 at the end of STOP, push a byte on the same edge as the pop -> count_o stays 1 and both bytes are transmitted in order.
- Reset mid-frame: deassert rst_ni during DATA bit 3 with 2 bytes queued -> serial_out=1 asynchronously, count_o=0, busy_o=0, ready_o=1. After release, no residual bits are sent.
- Loopback: connect serial_out to the team's UART receiver at matching CLKFREQ/BAUD and send 0x00..0xFF -> the receiver reports all 256 bytes correct and in order.
